tt_sweep_checker: RTL and testbench
===================================

# tt_sweep_checker

Synthesizable exhaustive truth-table checker for small combinational gates. On `start` it drives every input vector `0 … 2^N_IN-1` onto the DUT, waits a fixed settle interval, samples the DUT output, and compares it with a parameterized expected truth table. It reports `pass`/`done`, the number of mismatches, and the first failing vector. It sits beside a gate under test, such as an AND gate, as the on-chip response end of the stimulus/check loop. This lets gate-level days be self-checked in hardware or in a clocked bench, with no hand-written `$display` tables.

## Interface
Parameters:
- `N_IN`, default 2: DUT input width; range 1–8.
- `SETTLE`, default 1: cycles each vector is held before sampling; must be ≥1.
- `EXPECT_MAP`, default `4'b1000`: 2^N_IN bits. Bit `i` is the expected DUT output for input vector `i`. The default is the 2-input AND.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  async active-high reset
- `start`  in  1  begin a sweep; sampled only in IDLE
- `dut_in`  out  N_IN  vector driven to the DUT
- `dut_out`  in  1  DUT response
- `busy`  out  1  high while sweeping
- `done`  out  1  one-cycle pulse at end of sweep
- `pass`  out  1  1 = last sweep had zero mismatches; held until next start
- `err_count`  out  N_IN+1  mismatches in last/current sweep
- `fail_valid`  out  1  at least one mismatch recorded
- `first_fail_vec`  out  N_IN  first mismatching vector, valid when `fail_valid`=1

## Operation
- **State machine:** IDLE → APPLY → DONE → IDLE.
- **IDLE:**
  - `dut_in`=0, `busy`=0.
  - `start`=1 at an edge clears `err_count`, `fail_valid`, `first_fail_vec` and `pass`, then enters APPLY with vec=0 and wait counter=0.
- **APPLY:**
  - `dut_in`=vec, `busy`=1.
  - The counter increments each cycle.
  - At the edge where counter==SETTLE-1:
    - `dut_out` is compared with `EXPECT_MAP[vec]`.
    - On a mismatch, `err_count` increments.
    - If `fail_valid` was 0, `first_fail_vec`←vec and `fail_valid`←1.
  - After the compare, if vec==2^N_IN-1 the FSM goes to DONE; otherwise vec+1 and counter←0.
- **DONE:**
  - Lasts exactly one cycle: `done`=1, `busy`=0, `dut_in`=0.
  - `pass`←1 if `err_count`==0. The final compare's increment is already included.
  - Returns to IDLE.
- `start` is ignored in APPLY and DONE and is not queued.
- `err_count` width N_IN+1 holds the maximum value 2^N_IN without wrap.
- The vec counter never wraps; the terminal compare ends the sweep.
- **Reset:**
  - Asserting `rst` at any time, including mid-sweep, immediately forces IDLE.
  - All outputs go to 0: `dut_in`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `first_fail_vec`.
  - Partial results are discarded.

## Timing
- Each vector is held on `dut_in` for exactly SETTLE cycles, and `dut_out` is sampled at the last edge of that hold. The DUT must be combinational, with a path shorter than one cycle.
- `busy` rises the cycle after the edge that samples `start`.
- `done` is high during the cycle starting 2^N_IN·SETTLE edges after the `start`-sampling edge.
- After `done` the FSM is back in IDLE; `start` may be accepted at the edge ending the `done` cycle+1.
- All outputs are registered. There are no combinational paths from `dut_out` or `start` to any output.

## Configuration
- Macro: `TT_SWEEP_STOP_ON_FAIL_EN`.
- **Defined:**
  - The first mismatch ends the sweep. The next state is DONE, regardless of vec.
  - `err_count`=1, `pass`=0, and `first_fail_vec`=the failing vector.
  - `done` comes early, one cycle after the failing compare.
- **Undefined (default):**
  - All 2^N_IN vectors are always checked.
  - `err_count` is the total number of mismatches.

## Test plan
- **Correct AND DUT, SETTLE=2:** `start` at edge 0 → `dut_in` sequence 0,0,1,1,2,2,3,3. Then `done`=1 in the cycle after edge 8, with `pass`=1, `err_count`=0, `fail_valid`=0.
- **OR gate as DUT with default AND map:** full sweep → vectors 1 and 2 fail. Result `err_count`=2, `first_fail_vec`=1, `pass`=0.
- **Stuck-at-1 DUT with the macro defined:** the sweep stops at vec 0. `done` comes 1 cycle after the first compare, with `err_count`=1 and `first_fail_vec`=0.
- **`rst` pulsed mid-sweep (during vec 2):** all outputs read 0 within the reset. A new `start` then produces a full clean sweep with `pass`=1.
- **`start` held high throughout a sweep:** no restart while `busy`. A new sweep begins only after DONE→IDLE, and `err_count` is cleared at that restart.
- **N_IN=3, EXPECT_MAP=8'b1000_0000, 3-input AND DUT:** 8 vectors checked, `pass`=1, and `done` arrives 8·SETTLE edges after the start edge.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep checker: drives every input vector to a gate, compares against EXPECT_MAP.
// Optional TT_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module tt_sweep_checker #(
  parameter int                      N_IN       = 2,
  parameter int                      SETTLE     = 1,
  parameter logic [(1<<N_IN)-1:0]    EXPECT_MAP = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam int                CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0]   VEC_LAST = '1;
  localparam logic [N_IN:0]     ERR_ONE  = (N_IN+1)'(1);

  state_t            state_q;
  logic [N_IN-1:0]   vec_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [N_IN:0]     err_q;
  logic              fail_valid_q;
  logic [N_IN-1:0]   first_fail_q;

  logic              mismatch;
  logic [N_IN:0]     err_d;

  assign mismatch = (dut_out != EXPECT_MAP[vec_q]);
  assign err_d    = mismatch ? err_q + ERR_ONE : err_q;

  // NOTE: all state uses non-blocking assignment so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= APPLY;
            vec_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
          end
        end
        APPLY: begin
          if (cnt_q == CNT_LAST) begin
            err_q <= err_d;
            if (mismatch && !fail_valid_q) begin
              fail_valid_q <= 1'b1;
              first_fail_q <= vec_q;
            end
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
            if (vec_q == VEC_LAST || mismatch) begin
`else
            if (vec_q == VEC_LAST) begin
`endif
              state_q <= DONE;
              vec_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_q + 1'b1;
              cnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // vec_q is parked at 0 outside APPLY, so it drives the DUT directly.
  assign dut_in         = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: 2-input checker (SETTLE=2) against AND/OR/stuck-at-1 gates, 3-input checker against AND3.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // 2-input checker with selectable gate model: 0=AND, 1=OR, 2=stuck-at-1
  logic       start2 = 1'b0;
  logic [1:0] din2;
  logic       dout2;
  logic       busy2, done2, pass2, fv2;
  logic [2:0] err2;
  logic [1:0] ff2;
  int         mode = 0;

  always_comb begin
    dout2 = 1'b0;
    case (mode)
      0:       dout2 = din2[0] & din2[1];
      1:       dout2 = din2[0] | din2[1];
      default: dout2 = 1'b1;
    endcase
  end

  tt_sweep_checker #(.N_IN(2), .SETTLE(2), .EXPECT_MAP(4'b1000)) u_chk2 (
    .clk(clk), .rst(rst), .start(start2), .dut_in(din2), .dut_out(dout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .first_fail_vec(ff2)
  );

  logic       start3 = 1'b0;
  logic [2:0] din3;
  logic       busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] ff3;

  tt_sweep_checker #(.N_IN(3), .SETTLE(1), .EXPECT_MAP(8'b1000_0000)) u_chk3 (
    .clk(clk), .rst(rst), .start(start3), .dut_in(din3), .dut_out(&din3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .first_fail_vec(ff3)
  );

  // Pulse start for one edge, return the number of edges from the start edge to the done cycle.
  task automatic run_sweep(input bit use3, output int edges);
    @(negedge clk);
    if (use3) start3 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    start3 = 1'b0;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!(use3 ? done3 : done2) && edges < 100);
    check("sweep_timeout", int'(edges < 100), 1);
  endtask

  int edges;
  int seq_ok;

  initial begin
    #12;
    check("rst_din",   din2,  0);
    check("rst_busy",  busy2, 0);
    check("rst_done",  done2, 0);
    check("rst_pass",  pass2, 0);
    check("rst_err",   err2,  0);
    check("rst_fv",    fv2,   0);
    @(negedge clk);
    rst = 1'b0;

    // Correct AND, dut_in held two cycles per vector, done after edge 8
    mode = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("and_busy_rise", busy2, 1);
    seq_ok = 1;
    for (int k = 0; k < 8; k++) begin
      if (din2 !== 2'(k >> 1) || done2 !== 1'b0) seq_ok = 0;
      @(posedge clk); #1;
    end
    check("and_din_seq", seq_ok, 1);
    check("and_done",    done2, 1);
    check("and_busy_dn", busy2, 0);
    check("and_pass",    pass2, 1);
    check("and_err",     err2,  0);
    check("and_fv",      fv2,   0);
    @(posedge clk); #1;
    check("and_done_pulse", done2, 0);
    check("and_pass_hold",  pass2, 1);

    // OR gate against AND map: vectors 1 and 2 mismatch
    mode = 1;
    run_sweep(1'b0, edges);
    check("or_pass",  pass2, 0);
    check("or_fv",    fv2,   1);
    check("or_first", ff2,   1);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    check("or_err",   err2,  1);
    check("or_edges", edges, 4);
`else
    check("or_err",   err2,  2);
    check("or_edges", edges, 8);
`endif

    // Stuck-at-1: vectors 0,1,2 mismatch
    @(posedge clk); #1;
    mode = 2;
    run_sweep(1'b0, edges);
    check("sa1_pass",  pass2, 0);
    check("sa1_first", ff2,   0);
    check("sa1_fv",    fv2,   1);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    check("sa1_err",   err2,  1);
    check("sa1_edges", edges, 2);
`else
    check("sa1_err",   err2,  3);
    check("sa1_edges", edges, 8);
`endif

    // Reset asserted while vec 2 is applied, then a clean sweep
    @(posedge clk); #1;
    mode = 1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_vec2", din2, 2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_din",  din2,  0);
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_err",  err2,  0);
    check("mid_rst_fv",   fv2,   0);
    check("mid_rst_ff",   ff2,   0);
    check("mid_rst_pass", pass2, 0);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    run_sweep(1'b0, edges);
    check("post_rst_edges", edges, 8);
    check("post_rst_pass",  pass2, 1);

    // start held high: no restart while busy, restart clears err_count
    @(posedge clk); #1;
    mode = 1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    seq_ok = 1;
    do begin
      @(posedge clk); #1;
      edges++;
      if (!done2 && busy2 !== 1'b1) seq_ok = 0;
    end while (!done2 && edges < 100);
    check("hold_no_restart", seq_ok, 1);
    check("hold_err_nz",     int'(err2 != 0), 1);
    @(posedge clk); #1;
    check("hold_idle_busy",  busy2, 0);
    @(posedge clk); #1;
    check("hold_restart",    busy2, 1);
    check("hold_err_clear",  err2,  0);
    start2 = 1'b0;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done2 && edges < 100);
    check("hold_second_done", done2, 1);

    // 3-input AND, SETTLE=1
    @(posedge clk); #1;
    run_sweep(1'b1, edges);
    check("and3_edges", edges, 8);
    check("and3_pass",  pass3, 1);
    check("and3_err",   err3,  0);
    check("and3_fv",    fv3,   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
